// File: rtl/dp_mem_pkg.sv
// Shared defaults, port identifiers and MAR wrap-around helper for the dual-port memory.
package dp_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_id_t;

  // Increment modulo 2**width; callers narrow the result back to their MAR width.
  function automatic logic [31:0] addr_inc(input logic [31:0] addr, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (addr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/dp_mem_mar_if.sv
// Bus bundle for dp_mem_mar: MAR control, access strobes and read data per port.
// The collision output exists only when MEM_COLLISION_DETECT_EN is defined.
interface dp_mem_mar_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  load_mar_A, load_mar_B;
  logic                  inc_mar_A, inc_mar_B;
  logic [ADDR_WIDTH-1:0] mar_in_A, mar_in_B;
  logic [ADDR_WIDTH-1:0] mar_out_A, mar_out_B;
  logic                  bank_A, bank_B;
  logic                  load_A, load_B;
  logic                  oe_A, oe_B;
  logic [DATA_WIDTH-1:0] data_in_A, data_in_B;
  logic [DATA_WIDTH-1:0] data_out_A, data_out_B;
  logic                  rvalid_A, rvalid_B;
`ifdef MEM_COLLISION_DETECT_EN
  logic                  collision;

  modport master (
    output load_mar_A, load_mar_B, inc_mar_A, inc_mar_B, mar_in_A, mar_in_B,
           load_A, load_B, oe_A, oe_B, data_in_A, data_in_B,
    input  mar_out_A, mar_out_B, bank_A, bank_B, data_out_A, data_out_B,
           rvalid_A, rvalid_B, collision
  );
  modport slave (
    input  load_mar_A, load_mar_B, inc_mar_A, inc_mar_B, mar_in_A, mar_in_B,
           load_A, load_B, oe_A, oe_B, data_in_A, data_in_B,
    output mar_out_A, mar_out_B, bank_A, bank_B, data_out_A, data_out_B,
           rvalid_A, rvalid_B, collision
  );
`else
  modport master (
    output load_mar_A, load_mar_B, inc_mar_A, inc_mar_B, mar_in_A, mar_in_B,
           load_A, load_B, oe_A, oe_B, data_in_A, data_in_B,
    input  mar_out_A, mar_out_B, bank_A, bank_B, data_out_A, data_out_B,
           rvalid_A, rvalid_B
  );
  modport slave (
    input  load_mar_A, load_mar_B, inc_mar_A, inc_mar_B, mar_in_A, mar_in_B,
           load_A, load_B, oe_A, oe_B, data_in_A, data_in_B,
    output mar_out_A, mar_out_B, bank_A, bank_B, data_out_A, data_out_B,
           rvalid_A, rvalid_B
  );
`endif
endinterface

// File: rtl/dp_mem_mar_ctr.sv
// Memory address register with parallel load (priority) and wrap-around increment.
module mar_ctr
  import dp_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] mar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
    end else if (load) begin
      mar <= din;
    end else if (inc) begin
      mar <= ADDR_WIDTH'(addr_inc(32'(mar), ADDR_WIDTH));
    end
  end

endmodule

// File: rtl/dp_mem_mar.sv
// Dual-port RAM with one MAR per port, registered reads with valid pulse, port A wins write ties.
// Optional macro MEM_COLLISION_DETECT_EN adds a registered same-address collision pulse.
module dp_mem_mar
  import dp_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  dp_mem_mar_if.slave  bus
);

  localparam int       DEPTH        = 1 << ADDR_WIDTH;
  localparam port_id_t WRITE_WINNER = PORT_A;

  logic                  rst_meta_p0, rst_sync_p1;
  logic [ADDR_WIDTH-1:0] mar_a, mar_b;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_a_p1, data_b_p1;
  logic                  vld_a_p1, vld_b_p1;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_meta_p0 <= 1'b1;
      rst_sync_p1 <= rst_meta_p0;
    end
  end

  mar_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_mar_a (
    .clk   (clk),
    .rst_n (rst_sync_p1),
    .load  (bus.load_mar_A),
    .inc   (bus.inc_mar_A),
    .din   (bus.mar_in_A),
    .mar   (mar_a)
  );

  mar_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_mar_b (
    .clk   (clk),
    .rst_n (rst_sync_p1),
    .load  (bus.load_mar_B),
    .inc   (bus.inc_mar_B),
    .din   (bus.mar_in_B),
    .mar   (mar_b)
  );

  // The winning port's write is issued last so it overrides on an address tie.
  always_ff @(posedge clk) begin
    if (rst_sync_p1) begin
      if (WRITE_WINNER == PORT_A) begin
        if (bus.load_B) mem[mar_b] <= bus.data_in_B;
        if (bus.load_A) mem[mar_a] <= bus.data_in_A;
      end else begin
        if (bus.load_A) mem[mar_a] <= bus.data_in_A;
        if (bus.load_B) mem[mar_b] <= bus.data_in_B;
      end
    end
  end

  // Read stage: old contents are returned on a same-edge write.
  always_ff @(posedge clk or negedge rst_sync_p1) begin
    if (!rst_sync_p1) begin
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      vld_a_p1  <= 1'b0;
      vld_b_p1  <= 1'b0;
    end else begin
      if (bus.oe_A) data_a_p1 <= mem[mar_a];
      if (bus.oe_B) data_b_p1 <= mem[mar_b];
      vld_a_p1 <= bus.oe_A;
      vld_b_p1 <= bus.oe_B;
    end
  end

`ifdef MEM_COLLISION_DETECT_EN
  logic col_p1;

  always_ff @(posedge clk or negedge rst_sync_p1) begin
    if (!rst_sync_p1) begin
      col_p1 <= 1'b0;
    end else begin
      col_p1 <= (mar_a == mar_b) &&
                ((bus.load_A && bus.load_B) ||
                 (bus.load_A && bus.oe_B) ||
                 (bus.load_B && bus.oe_A));
    end
  end

  assign bus.collision = col_p1;
`endif

  assign bus.mar_out_A  = mar_a;
  assign bus.mar_out_B  = mar_b;
  assign bus.bank_A     = mar_a[ADDR_WIDTH-1];
  assign bus.bank_B     = mar_b[ADDR_WIDTH-1];
  assign bus.data_out_A = data_a_p1;
  assign bus.data_out_B = data_b_p1;
  assign bus.rvalid_A   = vld_a_p1;
  assign bus.rvalid_B   = vld_b_p1;

endmodule

// File: tb/tb_dp_mem_mar.sv
// Directed table-driven bench for dp_mem_mar plus a reset-preservation sequence.
module tb_dp_mem_mar;
  import dp_mem_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    logic          lm_a;  logic inc_a; logic [AW-1:0] min_a; logic ld_a; logic oe_a; logic [DW-1:0] din_a;
    logic          lm_b;  logic inc_b; logic [AW-1:0] min_b; logic ld_b; logic oe_b; logic [DW-1:0] din_b;
    logic [AW-1:0] mar_a; logic [AW-1:0] mar_b;
    logic [DW-1:0] do_a;  logic [DW-1:0] do_b;
    logic          rv_a;  logic rv_b;  logic col;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  vec_t post[$];

  always #5 clk = ~clk;

  dp_mem_mar_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dp_mem_mar #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.load_mar_A = v.lm_a; bus.inc_mar_A = v.inc_a; bus.mar_in_A = v.min_a;
    bus.load_A     = v.ld_a; bus.oe_A      = v.oe_a;  bus.data_in_A = v.din_a;
    bus.load_mar_B = v.lm_b; bus.inc_mar_B = v.inc_b; bus.mar_in_B = v.min_b;
    bus.load_B     = v.ld_b; bus.oe_B      = v.oe_b;  bus.data_in_B = v.din_b;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " mar_A"},  32'(bus.mar_out_A),  32'(v.mar_a));
    check({tag, " mar_B"},  32'(bus.mar_out_B),  32'(v.mar_b));
    check({tag, " bank_A"}, 32'(bus.bank_A),     32'(v.mar_a[AW-1]));
    check({tag, " bank_B"}, 32'(bus.bank_B),     32'(v.mar_b[AW-1]));
    check({tag, " dout_A"}, 32'(bus.data_out_A), 32'(v.do_a));
    check({tag, " dout_B"}, 32'(bus.data_out_B), 32'(v.do_b));
    check({tag, " rv_A"},   32'(bus.rvalid_A),   32'(v.rv_a));
    check({tag, " rv_B"},   32'(bus.rvalid_B),   32'(v.rv_b));
`ifdef MEM_COLLISION_DETECT_EN
    check({tag, " collision"}, 32'(bus.collision), 32'(v.col));
`endif
  endtask

  task automatic run_row(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_outputs(tag, v);
  endtask

  task automatic check_reset_state(input string tag);
    vec_t z;
    z = '{0,0,0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,0,8'h00,8'h00,0,0,0};
    check_outputs(tag, z);
  endtask

  initial begin
    vec_t idle;
    idle = '{0,0,0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,0,8'h00,8'h00,0,0,0};
    drive(idle);

    //          lmA iA minA ldA oeA dinA   lmB iB minB ldB oeB dinB   marA marB doA   doB   rvA rvB col
    vecs.push_back('{1,0,4'h2,0,0,8'h00, 0,0,4'h0,0,0,8'h00, 4'h2,4'h0,8'h00,8'h00,0,0,0});
    vecs.push_back('{1,0,4'h3,1,0,8'hAA, 0,0,4'h0,0,0,8'h00, 4'h3,4'h0,8'h00,8'h00,0,0,0});
    vecs.push_back('{0,0,4'h0,1,0,8'h55, 0,0,4'h0,0,0,8'h00, 4'h3,4'h0,8'h00,8'h00,0,0,0});
    vecs.push_back('{1,0,4'h2,0,0,8'h00, 1,0,4'h3,0,0,8'h00, 4'h2,4'h3,8'h00,8'h00,0,0,0});
    vecs.push_back('{0,0,4'h0,0,1,8'h00, 0,0,4'h0,0,1,8'h00, 4'h2,4'h3,8'hAA,8'h55,1,1,0});
    vecs.push_back('{0,0,4'h0,0,0,8'h00, 0,0,4'h0,0,0,8'h00, 4'h2,4'h3,8'hAA,8'h55,0,0,0});
    // MAR wrap: write E,F,0 then fetch-and-advance readback
    vecs.push_back('{1,0,4'hE,0,0,8'h00, 0,0,4'h0,0,0,8'h00, 4'hE,4'h3,8'hAA,8'h55,0,0,0});
    vecs.push_back('{0,1,4'h0,1,0,8'h11, 0,0,4'h0,0,0,8'h00, 4'hF,4'h3,8'hAA,8'h55,0,0,0});
    vecs.push_back('{0,1,4'h0,1,0,8'h22, 0,0,4'h0,0,0,8'h00, 4'h0,4'h3,8'hAA,8'h55,0,0,0});
    vecs.push_back('{0,0,4'h0,1,0,8'h33, 0,0,4'h0,0,0,8'h00, 4'h0,4'h3,8'hAA,8'h55,0,0,0});
    vecs.push_back('{1,0,4'hE,0,0,8'h00, 0,0,4'h0,0,0,8'h00, 4'hE,4'h3,8'hAA,8'h55,0,0,0});
    vecs.push_back('{0,1,4'h0,0,1,8'h00, 0,0,4'h0,0,0,8'h00, 4'hF,4'h3,8'h11,8'h55,1,0,0});
    vecs.push_back('{0,1,4'h0,0,1,8'h00, 0,0,4'h0,0,0,8'h00, 4'h0,4'h3,8'h22,8'h55,1,0,0});
    vecs.push_back('{0,1,4'h0,0,1,8'h00, 0,0,4'h0,0,0,8'h00, 4'h1,4'h3,8'h33,8'h55,1,0,0});
    vecs.push_back('{0,0,4'h0,0,0,8'h00, 0,0,4'h0,0,0,8'h00, 4'h1,4'h3,8'h33,8'h55,0,0,0});
    // Same-address double write: A wins
    vecs.push_back('{1,0,4'h5,0,0,8'h00, 1,0,4'h5,0,0,8'h00, 4'h5,4'h5,8'h33,8'h55,0,0,0});
    vecs.push_back('{0,0,4'h0,1,0,8'h77, 0,0,4'h0,1,0,8'h99, 4'h5,4'h5,8'h33,8'h55,0,0,1});
    vecs.push_back('{0,0,4'h0,0,1,8'h00, 0,0,4'h0,0,0,8'h00, 4'h5,4'h5,8'h77,8'h55,1,0,0});
    vecs.push_back('{0,0,4'h0,0,0,8'h00, 0,0,4'h0,0,1,8'h00, 4'h5,4'h5,8'h77,8'h77,0,1,0});
    // Cross-port read-during-write returns old data
    vecs.push_back('{1,0,4'h6,0,0,8'h00, 1,0,4'h6,0,0,8'h00, 4'h6,4'h6,8'h77,8'h77,0,0,0});
    vecs.push_back('{0,0,4'h0,1,0,8'hC3, 0,0,4'h0,0,0,8'h00, 4'h6,4'h6,8'h77,8'h77,0,0,0});
    vecs.push_back('{0,0,4'h0,1,0,8'h3C, 0,0,4'h0,0,1,8'h00, 4'h6,4'h6,8'h77,8'hC3,0,1,1});
    vecs.push_back('{0,0,4'h0,0,0,8'h00, 0,0,4'h0,0,1,8'h00, 4'h6,4'h6,8'h77,8'h3C,0,1,0});
    // Load beats increment; read uses pre-load MAR (6)
    vecs.push_back('{1,1,4'h9,0,1,8'h00, 0,0,4'h0,0,0,8'h00, 4'h9,4'h6,8'h3C,8'h3C,1,0,0});
    vecs.push_back('{0,0,4'h0,1,0,8'h5A, 0,0,4'h0,0,0,8'h00, 4'h9,4'h6,8'h3C,8'h3C,0,0,0});

    post.push_back('{1,0,4'h9,0,0,8'h00, 0,0,4'h0,0,0,8'h00, 4'h9,4'h0,8'h00,8'h00,0,0,0});
    post.push_back('{0,0,4'h0,0,1,8'h00, 0,0,4'h0,0,0,8'h00, 4'h9,4'h0,8'h5A,8'h00,1,0,0});
    post.push_back('{0,0,4'h0,0,0,8'h00, 0,0,4'h0,0,0,8'h00, 4'h9,4'h0,8'h5A,8'h00,0,0,0});

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) run_row($sformatf("row%0d", i), vecs[i]);

    // Reset mid-run: outputs clear asynchronously, memory contents survive
    @(negedge clk);
    drive(idle);
    rst = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (3) @(negedge clk);
    check_reset_state("held_reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    foreach (post[i]) run_row($sformatf("post%0d", i), post[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
